mem_stage: RTL and testbench



---
 rtl/mem_stage_if.sv | 17 +
 rtl/mem_stage.sv | 68 ++++++
 tb/tb_mem_stage.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// mem_stage_if: EX->MEM inputs, SRAM read data and MEM->WB/forwarding outputs of the memory stage.
interface mem_stage_if;
  logic [5:0]  stall;
  logic [87:0] ex_to_mem_bus;
  logic [31:0] data_sram_rdata;
  logic [69:0] mem_to_wb_bus;
  logic [37:0] mem_to_rf_bus;
  logic [1:0]  mem_excp;
  modport master (
    output stall, ex_to_mem_bus, data_sram_rdata,
    input  mem_to_wb_bus, mem_to_rf_bus, mem_excp
  );
  modport slave (
    input  stall, ex_to_mem_bus, data_sram_rdata,
    output mem_to_wb_bus, mem_to_rf_bus, mem_excp
  );
endinterface

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage with load extraction and a stall hold buffer for SRAM read data.
// Defining MEM_ALIGN_CHECK_EN enables load/store misalignment flags on mem_excp.
module mem_stage (
  input logic         clk,
  input logic         rst,
  mem_stage_if.slave  mem_io
);
  localparam logic Stop   = 1'b1;
  localparam logic NoStop = 1'b0;
  typedef enum logic {LIVE, HELD} state_e;
  state_e      state_q, state_d;
  logic [87:0] bus_q, bus_d;
  logic [31:0] hold_q, hold_d;
  logic        bubble, hold;
  logic        lb, lbu, lh, lhu, lw, sh, sw;
  logic [1:0]  a;
  logic [31:0] w, ld, wdata;
  logic [7:0]  b;
  logic [15:0] h;
  logic        adel, ades, we;
  logic        unused_ok;
  assign bubble = mem_io.stall[3] == Stop && mem_io.stall[4] == NoStop;
  assign hold   = mem_io.stall[3] == Stop && mem_io.stall[4] == Stop;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LIVE;
      bus_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      bus_q   <= bus_d;
      hold_q  <= hold_d;
    end
  end
  // SRAM data is only valid in the first MEM cycle, so capture it on entry to HELD
  always_comb begin
    bus_d   = bubble ? '0 : hold ? bus_q : mem_io.ex_to_mem_bus;
    state_d = hold ? HELD : LIVE;
    hold_d  = (hold && state_q == LIVE) ? mem_io.data_sram_rdata : hold_q;
  end
  assign {lb, lbu, lh, lhu, lw} = bus_q[87:83];
  assign sh = bus_q[81];
  assign sw = bus_q[80];
  assign a  = bus_q[1:0];
  always_comb begin
    w     = state_q == HELD ? hold_q : mem_io.data_sram_rdata;
    b     = a == 2'd0 ? w[7:0] : a == 2'd1 ? w[15:8] : a == 2'd2 ? w[23:16] : w[31:24];
    h     = a[1] ? w[31:16] : w[15:0];
    ld    = lb  ? {{24{b[7]}}, b} :
            lbu ? {24'b0, b} :
            lh  ? {{16{h[15]}}, h} :
            lhu ? {16'b0, h} :
            lw  ? w : '0;
    wdata = bus_q[38] ? ld : bus_q[31:0];
`ifdef MEM_ALIGN_CHECK_EN
    adel  = (lw && a != 2'd0) || ((lh || lhu) && a[0]);
    ades  = (sw && a != 2'd0) || (sh && a[0]);
`else
    adel  = 1'b0;
    ades  = 1'b0;
`endif
    we    = bus_q[37] && !adel;
  end
  assign mem_io.mem_to_wb_bus = {bus_q[79:48], we, bus_q[36:32], wdata};
  assign mem_io.mem_to_rf_bus = {we, bus_q[36:32], wdata};
  assign mem_io.mem_excp      = {adel, ades};
  assign unused_ok = ^{bus_q[82], bus_q[47:39], mem_io.stall[5], mem_io.stall[2:0], sh, sw};
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: vector table, directed stall/reset/alignment sequences and a randomized reference-model run.
module tb_mem_stage;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  mem_stage_if mif();
  mem_stage dut (.clk(clk), .rst(rst), .mem_io(mif));
  localparam logic [7:0] LB = 8'h80, LBU = 8'h40, LH = 8'h20, LHU = 8'h10, LW = 8'h08;
  localparam logic [7:0] SB = 8'h04, SH = 8'h02, SW = 8'h01;
  localparam logic [5:0] ST_NONE = 6'b000000, ST_BUB = 6'b001000, ST_HOLD = 6'b011000;
  int n_chk = 0;
  int n_fail = 0;
  typedef struct {
    logic [87:0] bus;
    logic [31:0] rd;
    logic [31:0] exp;
  } vec_t;
  vec_t tv[9];
  logic [87:0] m_bus;
  logic        m_first;
  logic [31:0] m_cap;
  function automatic logic [87:0] mk(input logic [7:0] op, input logic [31:0] pc, input logic sel,
                                     input logic we, input logic [4:0] wa, input logic [31:0] res);
    return {op, pc, op != 8'h00, 4'b0, 4'b0, sel, we, wa, res};
  endfunction
  task automatic chk(input string nm, input logic [69:0] act, input logic [69:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic drive(input logic [5:0] st, input logic [87:0] bus, input logic [31:0] rd);
    mif.stall = st;
    mif.ex_to_mem_bus = bus;
    mif.data_sram_rdata = rd;
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic void model_out(input logic [87:0] bi, input logic [31:0] w,
                                    output logic [69:0] wb, output logic [1:0] ex);
    logic [7:0]  op;
    logic [31:0] a, res, bv, hv, ld;
    logic        adel, ades;
    op  = bi[87:80];
    a   = {30'b0, bi[1:0]};
    res = bi[31:0];
    bv  = (w >> (8 * a)) & 32'hFF;
    hv  = (w >> ((a >= 2) ? 16 : 0)) & 32'hFFFF;
    if (op[7])      ld = (bv >= 32'd128) ? bv + 32'hFFFFFF00 : bv;
    else if (op[6]) ld = bv;
    else if (op[5]) ld = (hv >= 32'h8000) ? hv + 32'hFFFF0000 : hv;
    else if (op[4]) ld = hv;
    else if (op[3]) ld = w;
    else            ld = 32'h0;
    adel = 1'b0;
    ades = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    adel = (op[3] && a != 0) || ((op[5] || op[4]) && (a % 2 == 1));
    ades = (op[0] && a != 0) || (op[1] && (a % 2 == 1));
`endif
    wb = {bi[79:48], bi[37] && !adel, bi[36:32], bi[38] ? ld : res};
    ex = {adel, ades};
  endfunction
  initial begin
    logic [69:0] ewb;
    logic [1:0]  eex;
    logic [5:0]  st;
    logic [7:0]  op;
    int          k;
    tv[0] = '{mk(LB,  32'h100, 1'b1, 1'b1, 5'd5, 32'h1003), 32'h80FF1234, 32'hFFFFFF80};
    tv[1] = '{mk(LBU, 32'h104, 1'b1, 1'b1, 5'd6, 32'h1002), 32'h80FF1234, 32'h000000FF};
    tv[2] = '{mk(LB,  32'h108, 1'b1, 1'b1, 5'd7, 32'h1001), 32'h80FF1234, 32'h00000012};
    tv[3] = '{mk(LH,  32'h10C, 1'b1, 1'b1, 5'd8, 32'h2002), 32'h80010000, 32'hFFFF8001};
    tv[4] = '{mk(LHU, 32'h110, 1'b1, 1'b1, 5'd9, 32'h2002), 32'h80010000, 32'h00008001};
    tv[5] = '{mk(LH,  32'h114, 1'b1, 1'b1, 5'd10, 32'h2000), 32'h0000F00F, 32'hFFFFF00F};
    tv[6] = '{mk(LW,  32'h118, 1'b1, 1'b1, 5'd11, 32'h0), 32'h12345678, 32'h12345678};
    tv[7] = '{mk(8'h00, 32'h11C, 1'b0, 1'b1, 5'd12, 32'hCAFE0001), 32'h5A5A5A5A, 32'hCAFE0001};
    tv[8] = '{mk(8'h00, 32'h120, 1'b1, 1'b1, 5'd13, 32'h3), 32'hFFFFFFFF, 32'h0};
    rst = 1'b1;
    drive(ST_NONE, mk(LW, 32'hABC, 1'b1, 1'b1, 5'd1, 32'h0), 32'hFFFFFFFF);
    tick;
    tick;
    @(negedge clk);
    chk("reset wb", 70'(mif.mem_to_wb_bus), 70'h0);
    chk("reset rf", 70'(mif.mem_to_rf_bus), 70'h0);
    chk("reset excp", 70'(mif.mem_excp), 70'h0);
    rst = 1'b0;
    for (int i = 0; i < 9; i++) begin
      drive(ST_NONE, tv[i].bus, 32'h0);
      tick;
      mif.data_sram_rdata = tv[i].rd;
      @(negedge clk);
      chk($sformatf("vec%0d wb", i), 70'(mif.mem_to_wb_bus),
          {tv[i].bus[79:48], tv[i].bus[37], tv[i].bus[36:32], tv[i].exp});
      chk($sformatf("vec%0d rf", i), 70'(mif.mem_to_rf_bus),
          70'({tv[i].bus[37], tv[i].bus[36:32], tv[i].exp}));
      chk($sformatf("vec%0d excp", i), 70'(mif.mem_excp), 70'h0);
    end
    drive(ST_NONE, mk(LW, 32'h300, 1'b1, 1'b1, 5'd9, 32'h0), 32'h0);
    tick;
    drive(ST_HOLD, mif.ex_to_mem_bus, 32'h12345678);
    @(negedge clk);
    chk("hold c1", 70'(mif.mem_to_wb_bus[31:0]), 70'h12345678);
    tick;
    for (int c = 2; c <= 3; c++) begin
      mif.data_sram_rdata = 32'hDEADBEEF;
      @(negedge clk);
      chk($sformatf("hold c%0d", c), 70'(mif.mem_to_wb_bus[31:0]), 70'h12345678);
      tick;
    end
    drive(ST_NONE, mk(LW, 32'h304, 1'b1, 1'b1, 5'd10, 32'h4), 32'hDEADBEEF);
    @(negedge clk);
    chk("hold c4", 70'(mif.mem_to_wb_bus[31:0]), 70'h12345678);
    tick;
    mif.data_sram_rdata = 32'h55;
    @(negedge clk);
    chk("after release live", 70'(mif.mem_to_wb_bus), {32'h304, 1'b1, 5'd10, 32'h55});
    drive(ST_NONE, mk(8'h00, 32'h400, 1'b0, 1'b1, 5'd3, 32'hCAFE0001), 32'h0);
    tick;
    mif.stall = ST_BUB;
    @(negedge clk);
    chk("alu before bubble", 70'(mif.mem_to_wb_bus), {32'h400, 1'b1, 5'd3, 32'hCAFE0001});
    tick;
    @(negedge clk);
    chk("bubble wb", 70'(mif.mem_to_wb_bus), 70'h0);
    drive(ST_NONE, mk(LW, 32'h500, 1'b1, 1'b1, 5'd4, 32'h0), 32'h0);
    tick;
    drive(ST_HOLD, mif.ex_to_mem_bus, 32'hAAAA5555);
    tick;
    mif.data_sram_rdata = 32'h0;
    @(negedge clk);
    chk("held value", 70'(mif.mem_to_wb_bus[31:0]), 70'hAAAA5555);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    drive(ST_NONE, mk(LW, 32'h504, 1'b1, 1'b1, 5'd6, 32'h0), 32'h77);
    @(negedge clk);
    chk("rst in held wb", 70'(mif.mem_to_wb_bus), 70'h0);
    chk("rst in held rf", 70'(mif.mem_to_rf_bus), 70'h0);
    chk("rst in held excp", 70'(mif.mem_excp), 70'h0);
    tick;
    mif.data_sram_rdata = 32'h1;
    @(negedge clk);
    chk("lw after rst", 70'(mif.mem_to_wb_bus), {32'h504, 1'b1, 5'd6, 32'h1});
    drive(ST_NONE, mk(LW, 32'h600, 1'b1, 1'b1, 5'd3, 32'h1001), 32'h0);
    tick;
    mif.data_sram_rdata = 32'h11223344;
    @(negedge clk);
`ifdef MEM_ALIGN_CHECK_EN
    chk("lw misalign excp", 70'(mif.mem_excp), 70'h2);
    chk("lw misalign we", 70'(mif.mem_to_wb_bus[37]), 70'h0);
`else
    chk("lw misalign excp", 70'(mif.mem_excp), 70'h0);
    chk("lw misalign we", 70'(mif.mem_to_wb_bus[37]), 70'h1);
`endif
    chk("lw misalign data", 70'(mif.mem_to_wb_bus[31:0]), 70'h11223344);
    drive(ST_NONE, mk(SH, 32'h604, 1'b0, 1'b0, 5'd0, 32'h2003), 32'h0);
    tick;
    @(negedge clk);
`ifdef MEM_ALIGN_CHECK_EN
    chk("sh misalign excp", 70'(mif.mem_excp), 70'h1);
`else
    chk("sh misalign excp", 70'(mif.mem_excp), 70'h0);
`endif
    for (int i = 0; i < 400; i++) begin
      k  = $urandom_range(0, 5);
      st = (k <= 2) ? ST_NONE : (k == 3) ? ST_BUB : ST_HOLD;
      k  = $urandom_range(0, 8);
      op = (k == 8) ? 8'h00 : (8'h80 >> k);
      rst = (i == 0) || ($urandom_range(0, 31) == 0);
      drive(st, mk(op, $urandom, op[7:3] != 5'b0, op[2:0] == 3'b0, 5'($urandom), $urandom), $urandom);
      @(negedge clk);
      model_out(m_bus, m_first ? mif.data_sram_rdata : m_cap, ewb, eex);
      if (i > 0) begin
        chk($sformatf("rand%0d wb", i), 70'(mif.mem_to_wb_bus), ewb);
        chk($sformatf("rand%0d rf", i), 70'(mif.mem_to_rf_bus), 70'(ewb[37:0]));
        chk($sformatf("rand%0d excp", i), 70'(mif.mem_excp), 70'(eex));
      end
      @(posedge clk);
      if (rst) begin
        m_bus = '0;
        m_first = 1'b1;
        m_cap = '0;
      end else if (st[3] && !st[4]) begin
        m_bus = '0;
        m_first = 1'b1;
      end else if (!st[3]) begin
        m_bus = mif.ex_to_mem_bus;
        m_first = 1'b1;
      end else if (m_first) begin
        m_cap = mif.data_sram_rdata;
        m_first = 1'b0;
      end
      #1;
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
